uart_packet_parser: RTL and testbench
=====================================

// Module: uart_packet_parser
// PURPOSE
//  Receive-side packet decoder for uart_alu; takes the byte stream coming out of uart_rx.
//  Splits each packet into a header (opcode, reserved 0x00, length LSB, length MSB) and its payload bytes.
//  Publishes the header as sideband and forwards the payload as a valid/ready byte stream to the ALU datapath.
//  Detects malformed packets and resynchronises to the next header.
// PARAMETERS
//  datawidth_p       8         byte width of the in/out streams (must be 8)
//  timeout_cycles_p  4_000_000 idle cycles mid-packet before abort (~120 ms @ 33.178 MHz)
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   synchronous active-high reset
//  s_data_i     in   8   byte from uart_rx
//  s_valid_i    in   1   byte valid
//  s_ready_o    out  1   parser accepts byte
//  opcode_o     out  8   opcode of current packet; held until next header completes
//  length_o     out  16  length field of current packet (total bytes incl. 4-byte header); held
//  pkt_valid_o  out  1   1-cycle pulse: good header decoded
//  m_data_o     out  8   payload byte
//  m_valid_o    out  1   payload byte valid
//  m_ready_i    in   1   downstream accepts payload byte
//  m_last_o     out  1   qualifies the final payload byte of the packet
//  err_o        out  1   1-cycle pulse: packet error
//  err_code_o   out  2   0 bad reserved, 1 length<4, 2 unknown opcode, 3 timeout; held until next err
// BEHAVIOUR
//  Reset: state=HDR_OP; every output 0; s_ready_o=1 in the cycle after reset deasserts.
//  Handshake: a byte transfers when s_valid_i&&s_ready_o at posedge; likewise m_valid_o&&m_ready_i.
//  - m_valid_o stays high and m_data_o/m_last_o stay stable until accepted.
//  FSM states: HDR_OP, HDR_RSV, HDR_LEN_LO, HDR_LEN_HI, PAYLOAD, DRAIN.
//  - HDR_OP: capture opcode -> HDR_RSV.
//  - HDR_RSV: byte!=0x00 -> err code 0, go to HDR_OP; else -> HDR_LEN_LO.
//  - HDR_LEN_LO: capture LSB -> HDR_LEN_HI.
//  - HDR_LEN_HI: capture MSB; {MSB,LSB}=len, then decide:
//    - len<4 -> err code 1, go to HDR_OP.
//    - opcode not in pkg list -> err code 2, remaining=len-4, go to DRAIN (HDR_OP if remaining==0).
//    - otherwise update opcode_o/length_o, pulse pkt_valid_o next cycle, remaining=len-4.
//      Go to PAYLOAD, or HDR_OP if remaining==0 (no payload beats, no m_last_o).
//  - PAYLOAD: s_ready_o = !m_valid_o || m_ready_i (1-entry output register, full throughput).
//    - Each accepted byte loads m_data_o, m_valid_o=1 next cycle (latency 1), remaining--.
//    - m_last_o=1 when remaining==1 at acceptance; then -> HDR_OP.
//    - Next header bytes may be accepted while the last payload byte is still stalled.
//  - DRAIN: s_ready_o=1, bytes discarded, remaining--; at remaining==1 acceptance -> HDR_OP.
//  s_ready_o=1 in all states except PAYLOAD.
//  Timeout: idle counter clears on every accepted byte and in HDR_OP.
//  - Reaching timeout_cycles_p in any other state -> err code 3, go to HDR_OP.
//  - Any pending m_valid_o byte is still delivered (not dropped); m_last_o is not forced.
//  Simultaneous: err_o and pkt_valid_o never pulse in the same cycle.
//  - Timeout expiry coinciding with a byte acceptance: the byte wins, counter clears.
//  Width: remaining is 16-bit unsigned; len-4 computed only when len>=4, so it never wraps.
//  Reset mid-packet: FSM, counters and output register cleared; partial packet lost.
// STRUCTURE
//  Package uart_alu_pkg holds:
//  - opcodes OP_ECHO=8'hEC, OP_ADD32=8'hA0, OP_MUL32=8'hA1, OP_DIV32=8'hA2;
//  - HDR_BYTES_C=4;
//  - state enum parser_state_e;
//  - err_code_e.
//  Single module; the payload output register is inline, no sub-module.
// TESTING
//  1. Send A0 00 0C 00 + 8 bytes 01..08, m_ready_i=1:
//     pkt_valid_o once, opcode_o=A0, length_o=000C, 8 beats 01..08, m_last_o on 08, err_o never.
//  2. EC 00 04 00 -> pkt_valid_o pulse, zero payload beats.
//     Immediately follow with A1 00 05 00 FF -> one beat FF with m_last_o.
//  3. A0 01 ... -> err_o, err_code_o=0, back to HDR_OP.
//     Next good packet A0 00 05 00 7E parses correctly.
//  4. 55 00 06 00 AA BB -> err_code_o=2, AA/BB drained with no m_valid_o.
//     Then EC 00 05 00 33 yields beat 33.
//  5. A2 00 08 00 + 4 bytes with m_ready_i toggling 1010...: data order and values preserved, no loss or dup.
//     s_ready_o low while the register is full and unaccepted.
//  6. A0 00 08 00 11 then silence with timeout_cycles_p=100: beat 11 delivered, err_code_o=3 after 100 idle cycles.
//     Also rst_i during payload clears m_valid_o next cycle.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the uart_alu receive path: opcodes, header size,
// parser state encoding and error codes.
package uart_alu_pkg;

    localparam logic [7:0]  OP_ECHO     = 8'hEC;
    localparam logic [7:0]  OP_ADD32    = 8'hA0;
    localparam logic [7:0]  OP_MUL32    = 8'hA1;
    localparam logic [7:0]  OP_DIV32    = 8'hA2;

    // Header is opcode, reserved, length LSB, length MSB.
    localparam logic [15:0] HDR_BYTES_C = 16'd4;

    typedef enum logic [2:0] {
        HDR_OP,
        HDR_RSV,
        HDR_LEN_LO,
        HDR_LEN_HI,
        PAYLOAD,
        DRAIN
    } parser_state_e;

    typedef enum logic [1:0] {
        ERR_RSV     = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_OPCODE  = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_ECHO) || (op == OP_ADD32) ||
               (op == OP_MUL32) || (op == OP_DIV32);
    endfunction

endpackage

// File: rtl/uart_packet_parser.sv
// Splits the uart_rx byte stream into a 4-byte header (published as sideband)
// and a payload stream towards the ALU, with error detection and resync.
module uart_packet_parser
    import uart_alu_pkg::*;
#(
    parameter int datawidth_p      = 8,
    parameter int timeout_cycles_p = 4_000_000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [datawidth_p-1:0]   s_data_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    output logic [datawidth_p-1:0]   opcode_o,
    output logic [2*datawidth_p-1:0] length_o,
    output logic                     pkt_valid_o,
    output logic [datawidth_p-1:0]   m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     m_last_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o
);

    localparam int              TO_W    = $clog2(timeout_cycles_p + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles_p - 1);

    parser_state_e              state_q, state_d;
    logic [15:0]                rem_q, rem_d;
    logic [datawidth_p-1:0]     op_q, op_d;
    logic [datawidth_p-1:0]     len_lo_q, len_lo_d;
    logic [2*datawidth_p-1:0]   len_w;
    logic [TO_W-1:0]            idle_q, idle_d;
    logic                       acc, timeout_hit;
    logic                       hdr_ok, err_set, load, load_last;
    err_code_e                  err_code_d;

    // Only the payload state can backpressure; the 1-entry output register
    // still accepts a new byte in the same cycle its old one drains.
    assign s_ready_o = !rst_i &&
                       ((state_q != PAYLOAD) || !m_valid_o || m_ready_i);
    assign acc       = s_valid_i && s_ready_o;
    assign len_w     = {s_data_i, len_lo_q};
    // An accepted byte always beats a timeout that expires in the same cycle.
    assign timeout_hit = (state_q != HDR_OP) && (idle_q == TO_LAST);

    // Next-state, header decode and error classification.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        op_d       = op_q;
        len_lo_d   = len_lo_q;
        hdr_ok     = 1'b0;
        err_set    = 1'b0;
        err_code_d = ERR_RSV;
        load       = 1'b0;
        load_last  = 1'b0;
        idle_d     = (acc || state_q == HDR_OP || timeout_hit) ?
                     '0 : idle_q + TO_W'(1);
        if (acc) begin
            case (state_q)
                HDR_OP: begin
                    op_d    = s_data_i;
                    state_d = HDR_RSV;
                end
                HDR_RSV: begin
                    if (s_data_i != '0) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_RSV;
                        state_d    = HDR_OP;
                    end else begin
                        state_d = HDR_LEN_LO;
                    end
                end
                HDR_LEN_LO: begin
                    len_lo_d = s_data_i;
                    state_d  = HDR_LEN_HI;
                end
                HDR_LEN_HI: begin
                    if (len_w < HDR_BYTES_C) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = HDR_OP;
                    end else begin
                        // Subtraction only happens once len >= 4, so no wrap.
                        rem_d = len_w - HDR_BYTES_C;
                        if (!is_known_op(op_q)) begin
                            err_set    = 1'b1;
                            err_code_d = ERR_OPCODE;
                            state_d    = (rem_d == '0) ? HDR_OP : DRAIN;
                        end else begin
                            hdr_ok  = 1'b1;
                            state_d = (rem_d == '0) ? HDR_OP : PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    load      = 1'b1;
                    load_last = (rem_q == 16'd1);
                    rem_d     = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = HDR_OP;
                end
                DRAIN: begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = HDR_OP;
                end
                default: state_d = HDR_OP;
            endcase
        end else if (timeout_hit) begin
            err_set    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = HDR_OP;
        end
    end

    // Parser state, counters and registered header/error sideband.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= HDR_OP;
            rem_q       <= '0;
            op_q        <= '0;
            len_lo_q    <= '0;
            idle_q      <= '0;
            opcode_o    <= '0;
            length_o    <= '0;
            pkt_valid_o <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            len_lo_q    <= len_lo_d;
            idle_q      <= idle_d;
            pkt_valid_o <= hdr_ok;
            err_o       <= err_set;
            if (hdr_ok) begin
                opcode_o <= op_q;
                length_o <= len_w;
            end
            if (err_set) err_code_o <= err_code_d;
        end
    end

    // Payload output register: holds data/last stable until the sink accepts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
        end else if (load) begin
            m_valid_o <= 1'b1;
            m_data_o  <= s_data_i;
            m_last_o  <= load_last;
        end else if (m_valid_o && m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: a packet-level reference model
// queues expected headers/beats/errors; a monitor pops them as the DUT emits.
module tb_uart_packet_parser;
    import uart_alu_pkg::*;

    localparam int TO_C = 100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [7:0]  opcode_o;
    logic [15:0] length_o;
    logic        pkt_valid_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        m_last_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    always #5 clk = ~clk;

    uart_packet_parser #(.datawidth_p(8), .timeout_cycles_p(TO_C)) dut (
        .clk_i(clk), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .opcode_o(opcode_o), .length_o(length_o),
        .pkt_valid_o(pkt_valid_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_last_o(m_last_o), .err_o(err_o),
        .err_code_o(err_code_o)
    );

    typedef struct packed { logic [7:0] data; logic last; } beat_t;
    typedef struct packed { logic [7:0] op; logic [15:0] len; } hdr_t;

    beat_t      exp_beat[$];
    hdr_t       exp_hdr[$];
    logic [1:0] exp_err[$];
    logic [7:0] drv_q[$];
    bit         drv_pay[$];
    logic [7:0] pkt[$];

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
    bit gap_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic bit known(input logic [7:0] op);
        return op == 8'hEC || op == 8'hA0 || op == 8'hA1 || op == 8'hA2;
    endfunction

    // Reference model: walks a well-formed byte stream packet by packet.
    task automatic queue_stream(input logic [7:0] b[$]);
        int    i;
        int    len;
        beat_t bt;
        hdr_t  h;
        i = 0;
        while (i < b.size()) begin
            if (b[i+1] != 8'h00) begin
                exp_err.push_back(2'd0);
                for (int k = 0; k < 2; k++) begin drv_q.push_back(b[i+k]); drv_pay.push_back(1'b0); end
                i += 2;
            end else begin
                len = int'({b[i+3], b[i+2]});
                if (len < 4) begin
                    exp_err.push_back(2'd1);
                    for (int k = 0; k < 4; k++) begin drv_q.push_back(b[i+k]); drv_pay.push_back(1'b0); end
                    i += 4;
                end else if (!known(b[i])) begin
                    exp_err.push_back(2'd2);
                    for (int k = 0; k < len; k++) begin drv_q.push_back(b[i+k]); drv_pay.push_back(1'b0); end
                    i += len;
                end else begin
                    h.op  = b[i];
                    h.len = 16'(len);
                    exp_hdr.push_back(h);
                    for (int k = 0; k < len; k++) begin
                        drv_q.push_back(b[i+k]);
                        drv_pay.push_back(k >= 4);
                        if (k >= 4) begin
                            bt.data = b[i+k];
                            bt.last = (k == len - 1);
                            exp_beat.push_back(bt);
                        end
                    end
                    i += len;
                end
            end
        end
    endtask

    // Presents every queued byte; checks s_ready_o against the handshake rule.
    task automatic drive_all();
        logic [7:0] d;
        bit         p;
        bit         got;
        while (drv_q.size() > 0) begin
            d = drv_q.pop_front();
            p = drv_pay.pop_front();
            if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_valid_i = 1'b1;
            s_data_i  = d;
            got = 1'b0;
            for (int n = 0; n < 1000 && !got; n++) begin
                @(negedge clk);
                chk("s_ready", 64'(s_ready_o), p ? 64'(!(m_valid_o && !m_ready_i)) : 64'd1);
                got = s_ready_o;
                @(posedge clk); #1;
            end
            if (!got) fail_now("drive_timeout", 64'(d));
            s_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000 && (exp_beat.size() + exp_hdr.size() + exp_err.size()) != 0; n++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        chk("pending_beats", 64'(exp_beat.size()), 64'd0);
        chk("pending_hdrs",  64'(exp_hdr.size()),  64'd0);
        chk("pending_errs",  64'(exp_err.size()),  64'd0);
        @(posedge clk); #1;
    endtask

    task automatic monitor();
        beat_t      eb;
        hdr_t       eh;
        logic [1:0] ee;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (m_valid_o && m_ready_i) begin
                    if (exp_beat.size() == 0) fail_now("beat_unexpected", {m_data_o, m_last_o});
                    else begin
                        eb = exp_beat.pop_front();
                        chk("beat", 64'({m_data_o, m_last_o}), 64'({eb.data, eb.last}));
                    end
                end
                if (pkt_valid_o) begin
                    if (exp_hdr.size() == 0) fail_now("hdr_unexpected", {opcode_o, length_o});
                    else begin
                        eh = exp_hdr.pop_front();
                        chk("hdr", 64'({opcode_o, length_o}), 64'({eh.op, eh.len}));
                    end
                end
                if (err_o) begin
                    if (exp_err.size() == 0) fail_now("err_unexpected", 64'(err_code_o));
                    else begin
                        ee = exp_err.pop_front();
                        chk("err_code", 64'(err_code_o), 64'(ee));
                    end
                end
                if (err_o && pkt_valid_o) fail_now("err_and_pkt_same_cycle", 64'd1);
            end
        end
    endtask

    task automatic rdy_loop();
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready_i = 1'b1;
                1:       m_ready_i = ~m_ready_i;
                2:       m_ready_i = 1'($urandom_range(0, 1));
                default: m_ready_i = 1'b0;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] b[$]);
        queue_stream(b);
        drive_all();
        wait_idle();
    endtask

    initial begin
        int         cyc;
        int         kind;
        int         len;
        logic [7:0] op;
        hdr_t       h;
        beat_t      bt;
        rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b1;
        fork
            monitor();
            rdy_loop();
        join_none
        repeat (3) @(posedge clk); #1;
        chk("rst_ctl", 64'({s_ready_o, m_valid_o, pkt_valid_o, err_o, m_last_o}), 64'd0);
        chk("rst_data", 64'({opcode_o, length_o, m_data_o, err_code_o}), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_sready_after", 64'(s_ready_o), 64'd1);
        @(posedge clk); #1;

        // 1: basic packet with 8 payload bytes
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00};
        for (int k = 1; k <= 8; k++) pkt.push_back(8'(k));
        send(pkt);
        chk("opcode_held", 64'(opcode_o), 64'hA0);
        chk("length_held", 64'(length_o), 64'h000C);

        // 2: empty-payload packet back-to-back with a one-beat packet
        send('{8'hEC, 8'h00, 8'h04, 8'h00, 8'hA1, 8'h00, 8'h05, 8'h00, 8'hFF});

        // 3: bad reserved byte, then len<4 and len==0, then good packets
        send('{8'hA0, 8'h01, 8'hA0, 8'h00, 8'h05, 8'h00, 8'h7E});
        send('{8'hA1, 8'h00, 8'h03, 8'h00, 8'hA2, 8'h00, 8'h00, 8'h00,
               8'hA2, 8'h00, 8'h05, 8'h00, 8'h5A});

        // 4: unknown opcode drained, then a good packet
        send('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h33});
        chk("err_code_held", 64'(err_code_o), 64'd2);

        // 5: toggling sink backpressure
        rdy_mode = 1;
        pkt = '{8'hA2, 8'h00, 8'h08, 8'h00};
        for (int k = 0; k < 4; k++) pkt.push_back(8'($urandom_range(0, 255)));
        send(pkt);
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;

        // 6: truncated packet times out after the delivered byte
        h.op = 8'hA0; h.len = 16'h0008; exp_hdr.push_back(h);
        bt.data = 8'h11; bt.last = 1'b0; exp_beat.push_back(bt);
        exp_err.push_back(2'd3);
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h11};
        foreach (pkt[k]) begin drv_q.push_back(pkt[k]); drv_pay.push_back(k >= 4); end
        drive_all();
        cyc = 0;
        for (int n = 0; n < 300 && cyc == 0; n++) begin
            @(negedge clk);
            if (err_o) cyc = n + 1;
        end
        chk("timeout_latency", 64'(cyc), 64'(TO_C + 1));
        wait_idle();

        // reset while a payload byte is stalled in the output register
        rdy_mode = 3;
        h.op = 8'hA0; h.len = 16'h0008; exp_hdr.push_back(h);
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h22};
        foreach (pkt[k]) begin drv_q.push_back(pkt[k]); drv_pay.push_back(k >= 4); end
        drive_all();
        chk("stalled_valid", 64'({m_valid_o, m_data_o}), 64'({1'b1, 8'h22}));
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valid", 64'(m_valid_o), 64'd0);
        rst_i = 1'b0;
        rdy_mode = 0;
        wait_idle();

        // randomized mixed traffic
        rdy_mode = 2;
        gap_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            pkt.delete();
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                pkt = '{8'hA0, 8'($urandom_range(1, 255))};
            end else if (kind == 1) begin
                pkt = '{8'hA1, 8'h00, 8'($urandom_range(0, 3)), 8'h00};
            end else begin
                if (kind == 2) begin
                    op = 8'($urandom_range(0, 255));
                    while (known(op)) op = 8'($urandom_range(0, 255));
                end else begin
                    case ($urandom_range(0, 3))
                        0: op = OP_ECHO;  1: op = OP_ADD32;
                        2: op = OP_MUL32; default: op = OP_DIV32;
                    endcase
                end
                len = $urandom_range(4, 12);
                pkt = '{op, 8'h00, 8'(len), 8'h00};
                for (int k = 4; k < len; k++) pkt.push_back(8'($urandom_range(0, 255)));
            end
            queue_stream(pkt);
            drive_all();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
